// File: rtl/operand_sequencer.sv
// Sequences operand mux (A then B), issues to ALU, awaits result with timeout, then writes back.
// Accept-to-ISSUE 3 cycles, min 6 cycles accept-to-accept; alu_valid holds until alu_ready, instr_ready only in IDLE.
module operand_sequencer #(
    parameter int DATA_W  = 16,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [SEL_W-1:0]  instr_src1,
    input  logic [SEL_W-1:0]  instr_src2,
    input  logic [SEL_W-1:0]  instr_dst,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic [DATA_W-1:0] mux_data,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              wb_en,
    output logic [SEL_W-1:0]  wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL1  = 3'd1,
        S_SEL2  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_WB    = 3'd5
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       wait_cnt;
    logic [SEL_W-1:0] src2_q;
    logic             timeout_hit;

    // A result arriving on the last counted cycle takes priority over the timeout.
    assign timeout_hit = (state == S_WAIT) && !res_valid && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        alu_valid   = 1'b0;
        wb_en       = 1'b0;
        busy        = 1'b1;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
                if (instr_valid) state_nxt = S_SEL1;
            end
            S_SEL1:  state_nxt = S_SEL2;
            S_SEL2:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                alu_valid = 1'b1;
                if (alu_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid)        state_nxt = S_WB;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_WB: begin
                wb_en     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mux_sel  <= '0;
            src2_q   <= '0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= timeout_hit;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        alu_op  <= instr_op;
                        src2_q  <= instr_src2;
                        wb_addr <= instr_dst;
                        mux_sel <= instr_src1;
                    end
                end
                // mux_sel was registered a full cycle earlier, so mux_data has settled here.
                S_SEL1: begin
                    alu_a   <= mux_data;
                    mux_sel <= src2_q;
                end
                S_SEL2: begin
                    alu_b   <= mux_data;
                    mux_sel <= '0;
                end
                S_ISSUE: begin
                    if (alu_ready) wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (res_valid) wb_data  <= res_data;
                    else           wait_cnt <= wait_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a behavioural 16-entry operand mux and TIMEOUT=8.
module tb_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [3:0]  instr_src1;
    logic [3:0]  instr_src2;
    logic [3:0]  instr_dst;
    logic [3:0]  mux_sel;
    logic [15:0] mux_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        res_valid;
    logic [15:0] res_data;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        err;
    logic        busy;

    logic [15:0] mux_in [16];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    assign mux_data = mux_in[mux_sel];

    operand_sequencer #(.DATA_W(16), .SEL_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_src1(instr_src1), .instr_src2(instr_src2), .instr_dst(instr_dst),
        .mux_sel(mux_sel), .mux_data(mux_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b),
        .res_valid(res_valid), .res_data(res_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .err(err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] d);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_src1  = s1;
        instr_src2  = s2;
        instr_dst   = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mux_in[i] = 16'h0100 * 16'(i) + 16'h0011;
        mux_in[2]  = 16'h1234;
        mux_in[5]  = 16'h00FF;
        mux_in[15] = 16'hBEEF;

        rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_src1 = '0; instr_src2 = '0;
        instr_dst = '0; alu_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        step(); step();
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();
        chk("rst_instr_ready", instr_ready, 1);

        // Stray strobes while idle
        res_valid = 1'b1; res_data = 16'hDEAD; alu_ready = 1'b1;
        step(); step();
        chk("stray_busy", busy, 0);
        chk("stray_wb_data", wb_data, 0);
        chk("stray_wb_en", wb_en, 0);
        chk("stray_alu_valid", alu_valid, 0);
        res_valid = 1'b0; alu_ready = 1'b0;

        // Basic operation
        offer(4'd3, 4'd2, 4'd5, 4'd7);
        alu_ready = 1'b1;
        step();
        chk("basic_sel1_mux_sel", mux_sel, 2);
        chk("basic_sel1_ready", instr_ready, 0);
        chk("basic_sel1_busy", busy, 1);
        instr_valid = 1'b0;
        step();
        chk("basic_sel2_mux_sel", mux_sel, 5);
        chk("basic_sel2_alu_a", alu_a, 16'h1234);
        step();
        chk("basic_issue_valid", alu_valid, 1);
        chk("basic_issue_alu_a", alu_a, 16'h1234);
        chk("basic_issue_alu_b", alu_b, 16'h00FF);
        chk("basic_issue_op", alu_op, 3);
        chk("basic_issue_mux_sel", mux_sel, 0);
        step();
        chk("basic_wait_valid", alu_valid, 0);
        chk("basic_wait_wb_en", wb_en, 0);
        alu_ready = 1'b0; res_valid = 1'b1; res_data = 16'h1333;
        step();
        res_valid = 1'b0;
        chk("basic_wb_en", wb_en, 1);
        chk("basic_wb_addr", wb_addr, 7);
        chk("basic_wb_data", wb_data, 16'h1333);
        chk("basic_wb_err", err, 0);
        step();
        chk("basic_wb_drop", wb_en, 0);
        chk("basic_idle_ready", instr_ready, 1);

        // ALU backpressure: four ISSUE cycles with alu_ready low
        offer(4'd5, 4'd0, 4'd1, 4'd3);
        step();
        instr_valid = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", alu_valid, 1);
            chk("bp_alu_a", alu_a, 16'h0011);
            chk("bp_alu_b", alu_b, 16'h0111);
            chk("bp_op", alu_op, 5);
            step();
        end
        chk("bp_still_issue", alu_valid, 1);
        alu_ready = 1'b1;
        step();
        alu_ready = 1'b0;
        chk("bp_wait_valid", alu_valid, 0);
        chk("bp_wait_busy", busy, 1);
        res_valid = 1'b1; res_data = 16'hAAAA;
        step();
        res_valid = 1'b0;
        chk("bp_wb_en", wb_en, 1);
        chk("bp_wb_addr", wb_addr, 3);
        chk("bp_wb_data", wb_data, 16'hAAAA);
        step();

        // Timeout: 8 WAIT cycles, then err with no writeback
        offer(4'd1, 4'd4, 4'd6, 4'd9);
        alu_ready = 1'b1;
        step();
        instr_valid = 1'b0;
        step(); step(); step();
        alu_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_wait_err", err, 0);
            chk("to_wait_wb_en", wb_en, 0);
            chk("to_wait_busy", busy, 1);
            step();
        end
        chk("to_err_pulse", err, 1);
        chk("to_err_no_wb", wb_en, 0);
        chk("to_err_wb_data", wb_data, 16'hAAAA);
        step();
        chk("to_err_single", err, 0);
        chk("to_ready_after", instr_ready, 1);
        chk("to_no_wb_after", wb_en, 0);

        // Timeout tie: result on the final WAIT cycle wins
        offer(4'd2, 4'd2, 4'd2, 4'd4);
        alu_ready = 1'b1;
        step();
        instr_valid = 1'b0;
        step(); step(); step();
        alu_ready = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("tie_last_wait_busy", busy, 1);
        res_valid = 1'b1; res_data = 16'h5A5A;
        step();
        res_valid = 1'b0;
        chk("tie_wb_en", wb_en, 1);
        chk("tie_err", err, 0);
        chk("tie_wb_data", wb_data, 16'h5A5A);
        chk("tie_wb_addr", wb_addr, 4);
        step();
        chk("tie_err_after", err, 0);
        chk("tie_idle", instr_ready, 1);

        // Reset while in ISSUE
        offer(4'd7, 4'd5, 4'd2, 4'd1);
        step();
        instr_valid = 1'b0;
        step(); step();
        chk("rmid_issue", alu_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_alu_valid", alu_valid, 0);
        chk("rmid_alu_a", alu_a, 0);
        chk("rmid_alu_b", alu_b, 0);
        chk("rmid_alu_op", alu_op, 0);
        chk("rmid_wb_addr", wb_addr, 0);
        chk("rmid_wb_data", wb_data, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_mux_sel", mux_sel, 0);
        alu_ready = 1'b1; res_valid = 1'b1;
        step(); step();
        chk("rmid_no_wb", wb_en, 0);
        chk("rmid_no_err", err, 0);
        alu_ready = 1'b0; res_valid = 1'b0;

        // Same source for both operands, instr_valid held across the whole instruction
        offer(4'd9, 4'd15, 4'd15, 4'd2);
        alu_ready = 1'b1;
        step();
        chk("same_sel1", mux_sel, 15);
        step();
        chk("same_sel2", mux_sel, 15);
        step();
        chk("same_alu_a", alu_a, 16'hBEEF);
        chk("same_alu_b", alu_b, 16'hBEEF);
        chk("same_issue_ready", instr_ready, 0);
        step();
        chk("same_wait_busy", busy, 1);
        res_valid = 1'b1; res_data = 16'h0042;
        step();
        res_valid = 1'b0;
        chk("same_wb_en", wb_en, 1);
        chk("same_wb_busy", busy, 1);
        offer(4'd4, 4'd5, 4'd2, 4'd6);
        step();
        chk("held_idle_ready", instr_ready, 1);
        chk("held_idle_wb_en", wb_en, 0);
        step();
        instr_valid = 1'b0;
        chk("held_reaccept_busy", busy, 1);
        chk("held_reaccept_sel", mux_sel, 5);
        chk("held_reaccept_op", alu_op, 4);
        step(); step();
        chk("held2_alu_a", alu_a, 16'h00FF);
        chk("held2_alu_b", alu_b, 16'h1234);
        step();
        alu_ready = 1'b0;
        res_valid = 1'b1; res_data = 16'h1111;
        step();
        res_valid = 1'b0;
        chk("held2_wb_addr", wb_addr, 6);
        chk("held2_wb_data", wb_data, 16'h1111);
        step();
        chk("held2_idle", instr_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
